// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a program into instruction memory from address 0, holding the CPU in reset until loaded
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [DATA_WIDTH-1:0] im_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [DATA_WIDTH-1:0] checksum
);
  typedef enum logic [2:0] {IDLE, LOAD, RELEASE, RUN, ERROR} state_t;
  localparam logic [ADDR_WIDTH:0] last_idx = (ADDR_WIDTH+1)'(MAX_WORDS-1);
  state_t state, state_nx;
  logic acc, ovf, clr;
  assign acc = s_valid && state == LOAD;
  assign ovf = word_count == last_idx;
  assign clr = start && (state == IDLE || state == RUN || state == ERROR);
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, RUN, ERROR: state_nx = start ? LOAD : state;
      LOAD:             state_nx = !acc ? LOAD : s_last ? RELEASE : ovf ? ERROR : LOAD;
      RELEASE:          state_nx = RUN;
      default:          state_nx = IDLE;
    endcase
  end
  always_comb s_ready = state == LOAD;
  // cpu_reset/done lag the state by one edge so the final write settles before fetch
  always_ff @(posedge clk)
    if (!reset) begin
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
      checksum   <= '0;
    end else begin
      im_we     <= acc;
      im_addr   <= acc ? word_count[ADDR_WIDTH-1:0] : im_addr;
      im_wdata  <= acc ? s_data : im_wdata;
      cpu_reset <= !(state == RUN && !start);
      done      <= state == RUN && !start;
      err       <= (acc && !s_last && ovf) || (state == ERROR && !start);
      word_count <= clr ? '0 : acc ? word_count + 1'b1 : word_count;
      checksum   <= clr ? '0 : acc ? checksum + s_data : checksum;
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed checks of the boot loader on a default and a MAX_WORDS=4 instance
module tb_imem_boot_loader;
  logic clk = 0, reset = 0, start = 0, s_valid = 0, s_last = 0;
  logic [31:0] s_data = 0;
  logic rdy0, we0, cr0, dn0, er0, rdy1, we1, cr1, dn1, er1;
  logic [7:0] ad0, ad1;
  logic [31:0] wd0, wd1, ck0, ck1;
  logic [8:0] wc0, wc1;
  logic sel = 0;
  logic [31:0] mem0 [256], mem1 [256];
  int passed = 0, total = 0, n = 0;
  logic [31:0] sum = 0;
  always #5 clk = ~clk;
  imem_boot_loader u0 (.clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_ready(rdy0),
    .s_data(s_data), .s_last(s_last), .im_we(we0), .im_addr(ad0), .im_wdata(wd0), .cpu_reset(cr0),
    .done(dn0), .err(er0), .word_count(wc0), .checksum(ck0));
  imem_boot_loader #(.MAX_WORDS(4)) u1 (.clk(clk), .reset(reset), .start(start), .s_valid(s_valid),
    .s_ready(rdy1), .s_data(s_data), .s_last(s_last), .im_we(we1), .im_addr(ad1), .im_wdata(wd1),
    .cpu_reset(cr1), .done(dn1), .err(er1), .word_count(wc1), .checksum(ck1));
  always @(posedge clk) begin
    if (we0) mem0[ad0] <= wd0;
    if (we1) mem1[ad1] <= wd1;
  end
  wire        rdy = sel ? rdy1 : rdy0;
  wire        we  = sel ? we1 : we0;
  wire        cr  = sel ? cr1 : cr0;
  wire        dn  = sel ? dn1 : dn0;
  wire        er  = sel ? er1 : er0;
  wire [7:0]  ad  = sel ? ad1 : ad0;
  wire [31:0] wd  = sel ? wd1 : wd0;
  wire [31:0] ck  = sel ? ck1 : ck0;
  wire [8:0]  wc  = sel ? wc1 : wc0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 0;
    tick();
    reset = 1;
    n = 0;
    sum = 0;
  endtask
  task automatic do_start;
    start = 1;
    tick();
    start = 0;
    n = 0;
    sum = 0;
  endtask
  task automatic beat(input logic [31:0] d, input logic last);
    s_valid = 1;
    s_data = d;
    s_last = last;
    check("ready_before_beat", rdy, 1);
    tick();
    sum += d;
    check("we_on_accept", we, 1);
    check("addr", ad, n[7:0]);
    check("wdata", wd, d);
    check("word_count", wc, n + 1);
    check("checksum", ck, sum);
    n++;
    s_valid = 0;
    s_last = 0;
    s_data = 32'hDEAD_BEEF;
  endtask
  task automatic finish_release;
    check("cpu_reset_after_last", cr, 1);
    tick();
    check("we_in_release", we, 0);
    check("cpu_reset_release", cr, 1);
    check("done_release", dn, 0);
    tick();
    check("cpu_reset_run", cr, 0);
    check("done_run", dn, 1);
  endtask
  initial begin
    do_reset();
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      check("rst_we", we, 0);
      check("rst_addr", ad, 0);
      check("rst_wdata", wd, 0);
      check("rst_cpu_reset", cr, 1);
      check("rst_done", dn, 0);
      check("rst_err", er, 0);
      check("rst_wc", wc, 0);
      check("rst_ck", ck, 0);
      check("rst_ready", rdy, 0);
    end
    sel = 0;
    // basic back-to-back load
    do_start();
    for (int i = 1; i <= 5; i++) beat(i, i == 5);
    finish_release();
    check("basic_wc", wc, 5);
    check("basic_ck", ck, 32'h0000_000F);
    for (int i = 0; i < 5; i++) check("basic_mem", mem0[i], i + 1);
    // gaps between beats
    do_reset();
    do_start();
    for (int i = 1; i <= 5; i++) begin
      beat(i + 32'h10, i == 5);
      if (i < 5)
        for (int g = $urandom_range(1, 3); g > 0; g--) begin
          tick();
          check("gap_we", we, 0);
          check("gap_ready", rdy, 1);
        end
    end
    finish_release();
    check("gap_ck", ck, 32'h0000_005F);
    for (int i = 0; i < 5; i++) check("gap_mem", mem0[i], i + 32'h11);
    // reload from RUN, start during LOAD ignored
    start = 1;
    tick();
    start = 0;
    check("reload_cpu_reset", cr, 1);
    check("reload_done", dn, 0);
    check("reload_wc", wc, 0);
    check("reload_ck", ck, 0);
    n = 0;
    sum = 0;
    start = 1;
    beat(32'hFFFF_FFFF, 0);
    start = 0;
    beat(32'h0000_0002, 1);
    finish_release();
    check("reload_ck_wrap", ck, 32'h0000_0001);
    check("reload_wc2", wc, 2);
    check("reload_mem0", mem0[0], 32'hFFFF_FFFF);
    check("reload_mem1", mem0[1], 32'h0000_0002);
    check("reload_mem2", mem0[2], 32'h0000_0013);
    // reset mid-load
    do_reset();
    do_start();
    beat(32'hA, 0);
    beat(32'hB, 0);
    reset = 0;
    tick();
    reset = 1;
    check("abort_wc", wc, 0);
    check("abort_ck", ck, 0);
    check("abort_cpu_reset", cr, 1);
    check("abort_done", dn, 0);
    check("abort_ready", rdy, 0);
    tick();
    check("abort_mem0", mem0[0], 32'hA);
    check("abort_mem1", mem0[1], 32'hB);
    // overflow on MAX_WORDS=4
    sel = 1;
    do_reset();
    do_start();
    for (int i = 0; i < 4; i++) beat(32'h100 + i, 0);
    check("ovf_err", er, 1);
    check("ovf_cpu_reset", cr, 1);
    check("ovf_ready", rdy, 0);
    s_valid = 1;
    s_data = 32'h99;
    tick();
    s_valid = 0;
    check("ovf_no_accept_we", we, 0);
    check("ovf_wc_hold", wc, 4);
    check("ovf_err_hold", er, 1);
    for (int i = 0; i < 4; i++) check("ovf_mem", mem1[i], 32'h100 + i);
    do_start();
    check("ovf_err_clear", er, 0);
    check("ovf_restart_wc", wc, 0);
    check("ovf_restart_ready", rdy, 1);
    // s_last on the final permitted beat wins over overflow
    for (int i = 0; i < 4; i++) beat(32'h200 + i, i == 3);
    check("bound_err", er, 0);
    finish_release();
    check("bound_err_run", er, 0);
    check("bound_wc", wc, 4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
